distance_buffer_ctrl: RTL and testbench
=======================================

# distance_buffer_ctrl

Double-buffered controller for the per-column wall-distance memory consumed by the scanline renderer. The CPU side writes, bulk-fills and commits the back bank. The renderer side reads the front bank with fixed one-cycle latency. Bank swaps happen only at a frame boundary, so a frame never mixes two distance sets. The block sits between the CPU bus adapter and the GPU lookahead fetch stage, and replaces the static preloaded distance array.

## Interface
Parameters:
- COLUMNS, 320, number of valid distance entries per bank
- DATA_WIDTH, 16, width of one distance entry
- ADDR_WIDTH, 9, column address width

Ports:
- clk  input  1  system clock; the only clock
- clr  input  1  reset, synchronous, active-high
- frame_start  input  1  single-cycle pulse at start of vertical blank
- cpu_wr_req  input  1  write request
- cpu_wr_addr  input  ADDR_WIDTH  back-bank column address
- cpu_wr_data  input  DATA_WIDTH  write data
- cpu_wr_ack  output  1  single-cycle pulse, write accepted
- cpu_fill_req  input  1  pulse, fill whole back bank
- cpu_fill_data  input  DATA_WIDTH  fill value, sampled on acceptance
- cpu_swap_req  input  1  pulse, commit back bank at next frame_start
- swap_pending  output  1  swap requested, not yet performed
- busy  output  1  fill in progress
- front_bank  output  1  bank index currently visible to renderer
- gpu_rd_addr  input  ADDR_WIDTH  renderer column address
- gpu_rd_data  output  DATA_WIDTH  registered front-bank data

## Operation
- Storage: 2 banks × COLUMNS × DATA_WIDTH. back_bank = ~front_bank. Contents are not cleared by reset.
- FSM states:
  - IDLE
  - FILL
  - SWAP_WAIT
- IDLE transitions, in priority order:
  1. cpu_fill_req → FILL. cpu_fill_data is latched and the fill counter is set to 0.
  2. cpu_swap_req → SWAP_WAIT, and swap_pending sets.
  3. cpu_wr_req with cpu_wr_ack low → the write is accepted.
- A write is accepted only in IDLE and only when no fill or swap request is present in the same cycle.
- An accepted write with cpu_wr_addr < COLUMNS writes back_bank[addr]. An address ≥ COLUMNS is acked but dropped.
- cpu_wr_ack pulses for one cycle after acceptance. The requester must hold cpu_wr_req until it sees the ack. Back-to-back writes complete every 2 cycles.
- FILL: writes the latched value to back_bank[counter], one entry per cycle, for counter 0..COLUMNS-1. After entry COLUMNS-1 the FSM goes to IDLE, or to SWAP_WAIT if swap_pending is set. cpu_wr_req is not acked during FILL.
- cpu_swap_req during FILL sets swap_pending; the swap is serviced after the fill completes. cpu_fill_req during FILL or SWAP_WAIT is ignored.
- SWAP_WAIT: on frame_start, front_bank toggles, swap_pending clears, and the FSM goes to IDLE. CPU writes are stalled (no ack) until then.
- Renderer read: gpu_rd_data <= front_bank[gpu_rd_addr] every cycle. An address ≥ COLUMNS yields 0.
- Reset values:
  - state IDLE
  - front_bank 0
  - cpu_wr_ack 0
  - swap_pending 0
  - busy 0
  - gpu_rd_data 0
  - fill counter 0
- Reset mid-fill or mid-swap aborts the operation. Back-bank entries already written stay written.

## Timing
- gpu_rd_data is valid 1 cycle after gpu_rd_addr.
- A read issued in the frame_start cycle that performs a swap returns old-bank data. Reads from the next cycle onward see the new bank.
- Write accepted at edge T: memory is updated at T and cpu_wr_ack is high during cycle T+1.
- Fill accepted at edge T: busy is high in cycles T+1..T+COLUMNS, and entries 0..COLUMNS-1 are written at edges T+1..T+COLUMNS. The state is IDLE (or SWAP_WAIT) in cycle T+COLUMNS+1.
- frame_start in the same cycle as cpu_swap_req in IDLE does not swap. The swap waits for the next frame_start.
- swap_pending rises in the cycle after cpu_swap_req and falls in the cycle after the performing frame_start.
- A write to back_bank never affects gpu_rd_data before the swap.

## Test plan
- Reset, read addr 5 → gpu_rd_data 0, front_bank 0, all outputs 0. Write addr 5 = 16'h1234 → ack pulse 1 cycle later; read addr 5 before swap still returns the old front value.
- swap_req, then frame_start 10 cycles later → swap_pending high for those cycles, front_bank=1. Read addr 5 returns 16'h1234 one cycle after the address.
- fill_req with data 16'h00FF → busy high for exactly 320 cycles. Writes issued during the fill get no ack. After swap and frame_start, reads of addr 0, 159 and 319 return 16'h00FF.
- Write to addr 320 → acked, no entry changes. Read addr 400 → returns 0.
- swap_req during fill → swap_pending=1, FSM enters SWAP_WAIT after the fill, swap happens on the first frame_start after the fill. A frame_start during the fill does not swap.
- clr asserted at fill cycle 100 → next cycle state IDLE, busy 0, front_bank unchanged from reset value 0. Entries 0..99 hold the fill value; entries 100..319 are unchanged.

Source files
------------

// File: rtl/distance_buffer_ctrl.sv
// Double-buffered per-column wall-distance store: CPU writes/fills the back bank,
// the renderer reads the front bank, and banks swap only on a frame boundary.
module distance_buffer_ctrl #(
    parameter int COLUMNS    = 320,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  frame_start,
    input  logic                  cpu_wr_req,
    input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    output logic                  cpu_wr_ack,
    input  logic                  cpu_fill_req,
    input  logic [DATA_WIDTH-1:0] cpu_fill_data,
    input  logic                  cpu_swap_req,
    output logic                  swap_pending,
    output logic                  busy,
    output logic                  front_bank,
    input  logic [ADDR_WIDTH-1:0] gpu_rd_addr,
    output logic [DATA_WIDTH-1:0] gpu_rd_data
);

    localparam int                  IW     = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(COLUMNS);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(COLUMNS - 1);
    localparam logic [IW-1:0]       COLS_I = IW'(COLUMNS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SWAP_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_fill_cnt;
    logic [ADDR_WIDTH-1:0]   w_fill_cnt_next;
    logic [DATA_WIDTH-1:0]   r_fill_data;
    logic                    r_swap_pending;
    logic                    r_front_bank;
    logic                    r_wr_ack;
    logic                    w_fill_start;
    logic                    w_swap_set;
    logic                    w_swap_do;
    logic                    w_wr_accept;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_col;
    logic [DATA_WIDTH-1:0]   w_mem_data;
    logic [IW-1:0]           w_wr_idx;
    logic [IW-1:0]           w_rd_idx;
    logic [DATA_WIDTH-1:0]   r_rd_data;

    // Both banks share one array: bank 0 occupies [0, COLUMNS), bank 1 [COLUMNS, 2*COLUMNS).
    logic [DATA_WIDTH-1:0]   r_mem [0:2*COLUMNS-1];

    always_comb begin
        w_state_next    = r_state;
        w_fill_cnt_next = r_fill_cnt;
        w_fill_start    = 1'b0;
        w_swap_set      = 1'b0;
        w_swap_do       = 1'b0;
        w_wr_accept     = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_col       = cpu_wr_addr;
        w_mem_data      = cpu_wr_data;
        case (r_state)
            ST_IDLE: begin
                if (cpu_fill_req) begin
                    w_state_next    = ST_FILL;
                    w_fill_start    = 1'b1;
                    w_fill_cnt_next = '0;
                end else if (cpu_swap_req) begin
                    w_state_next = ST_SWAP_WAIT;
                    w_swap_set   = 1'b1;
                end else if (cpu_wr_req && !r_wr_ack) begin
                    // Out-of-range addresses are acknowledged but never reach the array.
                    w_wr_accept = 1'b1;
                    w_mem_we    = (cpu_wr_addr < COLS_A);
                end
            end
            ST_FILL: begin
                w_mem_we   = 1'b1;
                w_mem_col  = r_fill_cnt;
                w_mem_data = r_fill_data;
                w_swap_set = cpu_swap_req;
                if (r_fill_cnt == LAST_A) begin
                    w_fill_cnt_next = '0;
                    w_state_next    = (r_swap_pending || cpu_swap_req) ? ST_SWAP_WAIT : ST_IDLE;
                end else begin
                    w_fill_cnt_next = r_fill_cnt + 1'b1;
                end
            end
            ST_SWAP_WAIT: begin
                if (frame_start) begin
                    w_swap_do    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Writes always target the back bank (the one not being displayed).
    always_comb begin
        w_wr_idx = r_front_bank ? {1'b0, w_mem_col} : ({1'b0, w_mem_col} + COLS_I);
        w_rd_idx = r_front_bank ? ({1'b0, gpu_rd_addr} + COLS_I) : {1'b0, gpu_rd_addr};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state        <= ST_IDLE;
            r_fill_cnt     <= '0;
            r_fill_data    <= '0;
            r_swap_pending <= 1'b0;
            r_front_bank   <= 1'b0;
            r_wr_ack       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fill_cnt <= w_fill_cnt_next;
            r_wr_ack   <= w_wr_accept;
            if (w_fill_start) begin
                r_fill_data <= cpu_fill_data;
            end
            if (w_swap_set) begin
                r_swap_pending <= 1'b1;
            end else if (w_swap_do) begin
                r_swap_pending <= 1'b0;
            end
            if (w_swap_do) begin
                r_front_bank <= ~r_front_bank;
            end
        end
    end

    // Reset aborts a fill without touching entries already written.
    always_ff @(posedge clk) begin
        if (w_mem_we && !clr) begin
            r_mem[w_wr_idx] <= w_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_rd_data <= '0;
        end else if (gpu_rd_addr < COLS_A) begin
            r_rd_data <= r_mem[w_rd_idx];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign cpu_wr_ack   = r_wr_ack;
    assign swap_pending = r_swap_pending;
    assign busy         = (r_state == ST_FILL);
    assign front_bank   = r_front_bank;
    assign gpu_rd_data  = r_rd_data;

endmodule

// File: tb/tb_distance_buffer_ctrl.sv
// Self-checking bench for distance_buffer_ctrl: randomized writes/fills checked
// against a two-bank array model updated from the block's documented rules.
module tb_distance_buffer_ctrl;

    localparam int COLS = 320;
    localparam int DW   = 16;
    localparam int AW   = 9;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          frame_start = 1'b0;
    logic          cpu_wr_req = 1'b0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic          cpu_wr_ack;
    logic          cpu_fill_req = 1'b0;
    logic [DW-1:0] cpu_fill_data = '0;
    logic          cpu_swap_req = 1'b0;
    logic          swap_pending;
    logic          busy;
    logic          front_bank;
    logic [AW-1:0] gpu_rd_addr = '0;
    logic [DW-1:0] gpu_rd_data;

    always #5 clk = ~clk;

    distance_buffer_ctrl #(.COLUMNS(COLS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .clr          (clr),
        .frame_start  (frame_start),
        .cpu_wr_req   (cpu_wr_req),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ack   (cpu_wr_ack),
        .cpu_fill_req (cpu_fill_req),
        .cpu_fill_data(cpu_fill_data),
        .cpu_swap_req (cpu_swap_req),
        .swap_pending (swap_pending),
        .busy         (busy),
        .front_bank   (front_bank),
        .gpu_rd_addr  (gpu_rd_addr),
        .gpu_rd_data  (gpu_rd_data)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] ref_mem [2][COLS];
    logic          ref_front = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        gpu_rd_addr = a;
        step();
        d = gpu_rd_data;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!cpu_wr_ack && lat < 20);
        cpu_wr_req = 1'b0;
        if (cpu_wr_ack && int'(a) < COLS) ref_mem[~ref_front][a] = d;
    endtask

    task automatic request_swap();
        cpu_swap_req = 1'b1;
        step();
        cpu_swap_req = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Drives a fill and optional events at chosen fill-counter positions.
    task automatic run_fill(input logic [DW-1:0] d, input int swap_at, input int frame_at,
                            input int clr_at, input bit wr_during,
                            output int busy_cyc, output int acks);
        logic fb;
        int   cyc;
        fb            = ~ref_front;
        cpu_fill_req  = 1'b1;
        cpu_fill_data = d;
        step();
        cpu_fill_req  = 1'b0;
        cpu_fill_data = DW'($urandom);
        cpu_wr_addr   = AW'($urandom_range(0, COLS - 1));
        cpu_wr_data   = DW'($urandom);
        cyc = 0;
        busy_cyc = 0;
        acks = 0;
        while (busy && cyc < 1000) begin
            busy_cyc++;
            if (cpu_wr_ack) acks++;
            cpu_wr_req   = wr_during;
            cpu_swap_req = (cyc == swap_at);
            frame_start  = (cyc == frame_at);
            clr          = (cyc == clr_at);
            step();
            cyc++;
            cpu_swap_req = 1'b0;
            frame_start  = 1'b0;
            clr          = 1'b0;
        end
        if (cpu_wr_ack) acks++;
        cpu_wr_req = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (clr_at < 0 || i < clr_at) ref_mem[fb][i] = d;
        end
        if (clr_at >= 0) ref_front = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        ref_front = 1'b0;
        n_tests++; if (gpu_rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data got=%h exp=0", gpu_rd_data); end
        n_tests++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL rst_front got=%b exp=0", front_bank); end
        n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending got=%b exp=0", swap_pending); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_tests++; if (cpu_wr_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b exp=0", cpu_wr_ack); end
        rd(9'd400, d);
        n_tests++; if (d !== '0) begin n_fail++; $display("FAIL rst_rd_oob got=%h exp=0", d); end
        $display("[TB] reset checked");
    endtask

    task automatic test_init_banks();
        int bc, ac;
        for (int b = 0; b < 2; b++) begin
            run_fill(DW'($urandom), -1, -1, -1, 1'b0, bc, ac);
            n_tests++; if (bc !== COLS) begin n_fail++; $display("FAIL init_busy got=%0d exp=%0d", bc, COLS); end
            request_swap();
            n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL init_pending got=%b exp=1", swap_pending); end
            pulse_frame();
            ref_front = ~ref_front;
            n_tests++; if (front_bank !== ref_front) begin n_fail++; $display("FAIL init_front got=%b exp=%b", front_bank, ref_front); end
            $display("[TB] init bank fill %0d busy=%0d front=%b", b, bc, front_bank);
        end
    endtask

    task automatic test_write_swap();
        logic [DW-1:0] d;
        logic          old_front;
        int            lat, low_cnt;
        rd(9'd5, d);
        n_tests++; if (d !== ref_mem[ref_front][5]) begin n_fail++; $display("FAIL ws_rd_pre got=%h exp=%h", d, ref_mem[ref_front][5]); end
        wr(9'd5, 16'h1234, lat);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL ws_ack_lat got=%0d exp=1", lat); end
        step();
        n_tests++; if (cpu_wr_ack !== 1'b0) begin n_fail++; $display("FAIL ws_ack_pulse got=%b exp=0", cpu_wr_ack); end
        rd(9'd5, d);
        n_tests++; if (d !== ref_mem[ref_front][5]) begin n_fail++; $display("FAIL ws_rd_noswap got=%h exp=%h", d, ref_mem[ref_front][5]); end
        cpu_swap_req = 1'b1;
        frame_start  = 1'b1;
        step();
        cpu_swap_req = 1'b0;
        frame_start  = 1'b0;
        n_tests++; if (front_bank !== ref_front) begin n_fail++; $display("FAIL ws_same_cycle_front got=%b exp=%b", front_bank, ref_front); end
        n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL ws_pending_rise got=%b exp=1", swap_pending); end
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (swap_pending !== 1'b1) low_cnt++;
        end
        n_tests++; if (low_cnt !== 0) begin n_fail++; $display("FAIL ws_pending_hold low_cycles=%0d exp=0", low_cnt); end
        old_front   = ref_front;
        gpu_rd_addr = 9'd5;
        pulse_frame();
        ref_front = ~ref_front;
        n_tests++; if (gpu_rd_data !== ref_mem[old_front][5]) begin n_fail++; $display("FAIL ws_rd_swap_cycle got=%h exp=%h", gpu_rd_data, ref_mem[old_front][5]); end
        n_tests++; if (front_bank !== ref_front) begin n_fail++; $display("FAIL ws_front got=%b exp=%b", front_bank, ref_front); end
        n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL ws_pending_fall got=%b exp=0", swap_pending); end
        step();
        n_tests++; if (gpu_rd_data !== 16'h1234) begin n_fail++; $display("FAIL ws_rd_post got=%h exp=1234", gpu_rd_data); end
        $display("[TB] write+swap front=%b rd5=%h", front_bank, gpu_rd_data);
    endtask

    task automatic test_fill();
        logic [DW-1:0] d;
        int            bc, ac;
        logic [AW-1:0] addrs [3];
        addrs[0] = 9'd0; addrs[1] = 9'd159; addrs[2] = 9'd319;
        run_fill(16'h00FF, -1, -1, -1, 1'b1, bc, ac);
        n_tests++; if (bc !== COLS) begin n_fail++; $display("FAIL fill_busy got=%0d exp=%0d", bc, COLS); end
        n_tests++; if (ac !== 0) begin n_fail++; $display("FAIL fill_wr_acked got=%0d exp=0", ac); end
        request_swap();
        pulse_frame();
        ref_front = ~ref_front;
        for (int i = 0; i < 3; i++) begin
            rd(addrs[i], d);
            n_tests++; if (d !== 16'h00FF) begin n_fail++; $display("FAIL fill_rd addr=%0d got=%h exp=00ff", addrs[i], d); end
        end
        $display("[TB] fill busy=%0d acks=%0d", bc, ac);
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d;
        int            lat, bad, first_bad;
        wr(9'd320, DW'($urandom), lat);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL oob_ack320 lat=%0d exp=1", lat); end
        wr(AW'($urandom_range(321, 511)), DW'($urandom), lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL oob_ack_hi lat=%0d exp=2", lat); end
        rd(9'd400, d);
        n_tests++; if (d !== '0) begin n_fail++; $display("FAIL oob_rd400 got=%h exp=0", d); end
        for (int pass = 0; pass < 2; pass++) begin
            bad = 0;
            first_bad = -1;
            for (int i = 0; i < COLS; i++) begin
                rd(AW'(i), d);
                if (d !== ref_mem[ref_front][i]) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL oob_scan pass=%0d bad_entries=%0d first=%0d exp=0", pass, bad, first_bad); end
            request_swap();
            pulse_frame();
            ref_front = ~ref_front;
        end
        $display("[TB] out-of-range writes/reads done");
    endtask

    task automatic test_swap_during_fill();
        logic [DW-1:0] v, d;
        logic          old_front;
        logic [AW-1:0] a;
        int            bc, ac, stall_acks;
        v = DW'($urandom);
        old_front = ref_front;
        run_fill(v, 50, 150, -1, 1'b0, bc, ac);
        n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL sdf_pending got=%b exp=1", swap_pending); end
        n_tests++; if (front_bank !== old_front) begin n_fail++; $display("FAIL sdf_no_early_swap got=%b exp=%b", front_bank, old_front); end
        n_tests++; if (bc !== COLS) begin n_fail++; $display("FAIL sdf_busy got=%0d exp=%0d", bc, COLS); end
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = AW'($urandom_range(0, COLS - 1));
        cpu_wr_data = ~v;
        stall_acks  = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cpu_wr_ack) stall_acks++;
        end
        cpu_wr_req = 1'b0;
        n_tests++; if (stall_acks !== 0) begin n_fail++; $display("FAIL sdf_stall acks=%0d exp=0", stall_acks); end
        pulse_frame();
        ref_front = ~ref_front;
        n_tests++; if (front_bank !== ref_front) begin n_fail++; $display("FAIL sdf_front got=%b exp=%b", front_bank, ref_front); end
        n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL sdf_pending_clr got=%b exp=0", swap_pending); end
        for (int i = 0; i < 4; i++) begin
            a = AW'($urandom_range(0, COLS - 1));
            rd(a, d);
            n_tests++; if (d !== v) begin n_fail++; $display("FAIL sdf_rd addr=%0d got=%h exp=%h", a, d, v); end
        end
        $display("[TB] swap during fill front=%b", front_bank);
    endtask

    task automatic test_clr_mid_fill();
        logic [DW-1:0] v, d;
        logic          fb;
        int            bc, ac, lat, bad, first_bad;
        fb = ~ref_front;
        v  = ref_mem[fb][150] ^ 16'hA5A5;
        run_fill(v, -1, -1, 100, 1'b0, bc, ac);
        n_tests++; if (bc !== 101) begin n_fail++; $display("FAIL clr_busy_cycles got=%0d exp=101", bc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got=%b exp=0", busy); end
        n_tests++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL clr_front got=%b exp=0", front_bank); end
        n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL clr_pending got=%b exp=0", swap_pending); end
        wr(AW'($urandom_range(0, COLS - 1)), DW'($urandom), lat);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL clr_idle_write lat=%0d exp=1", lat); end
        if (fb != ref_front) begin
            request_swap();
            pulse_frame();
            ref_front = ~ref_front;
        end
        n_tests++; if (front_bank !== fb) begin n_fail++; $display("FAIL clr_view_front got=%b exp=%b", front_bank, fb); end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < COLS; i++) begin
            rd(AW'(i), d);
            if (d !== ref_mem[fb][i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL clr_scan bad_entries=%0d first=%0d exp=0", bad, first_bad); end
        $display("[TB] clear mid-fill busy_cycles=%0d", bc);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int            lat, bad, first_bad;
        step();
        step();
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(COLS, 511)) : AW'($urandom_range(0, COLS - 1));
            wr(a, DW'($urandom), lat);
            n_tests++; if (lat !== ((i == 0) ? 1 : 2)) begin n_fail++; $display("FAIL b2b_lat idx=%0d got=%0d exp=%0d", i, lat, (i == 0) ? 1 : 2); end
        end
        for (int i = 0; i < 6; i++) begin
            a = AW'($urandom_range(0, COLS - 1));
            rd(a, d);
            n_tests++; if (d !== ref_mem[ref_front][a]) begin n_fail++; $display("FAIL b2b_front addr=%0d got=%h exp=%h", a, d, ref_mem[ref_front][a]); end
        end
        request_swap();
        pulse_frame();
        ref_front = ~ref_front;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < COLS; i++) begin
            rd(AW'(i), d);
            if (d !== ref_mem[ref_front][i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_scan bad_entries=%0d first=%0d exp=0", bad, first_bad); end
        $display("[TB] back-to-back writes front=%b", front_bank);
    endtask

    initial begin
        test_reset();
        test_init_banks();
        test_write_swap();
        test_fill();
        test_out_of_range();
        test_swap_during_fill();
        test_clr_mid_fill();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout sim_time=%0t limit=2000000", $time);
        $fatal(1, "timeout");
    end

endmodule
